// File: rtl/shift_deserializer_pkg.sv
// Shared shift-register definitions: state encodings and default width.
// Used by the deserializer, the parallel-load shift register and future TX.
package shift_defs;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/shift_deserializer_cell.sv
// deser_cell: one bit of the deserializer shadow register.
// dir=1 takes the MSB-side neighbour, dir=0 the LSB-side neighbour.
module deser_cell (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic dir,
  input  logic left_nbr,
  input  logic right_nbr,
  output logic q
);

  always_ff @(posedge clock) begin
    if (reset)
      q <= 1'b0;
    else if (en)
      q <= dir ? left_nbr : right_nbr;
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with Valid/Ack handshake.
// Optional trailing even-parity bit: define PARITY_CHECK_EN.
module shift_deserializer
  import shift_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic             ShiftEn,
  input  logic             SerialIn,
  input  logic             RightIn,
  input  logic             Ack,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Busy,
  output logic             ParityErr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word_n;
  logic             take;
  logic             last;
  logic             clr;

  assign take = (state == SHIFT) && ShiftEn;
  assign last = take && (count == LAST);
  assign clr  = reset || ((state == IDLE) && Start);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic l_nbr;
    logic r_nbr;
    if (i == WIDTH - 1) begin : g_msb
      assign l_nbr = SerialIn;
    end else begin : g_mid_l
      assign l_nbr = shadow[i+1];
    end
    if (i == 0) begin : g_lsb
      assign r_nbr = SerialIn;
    end else begin : g_mid_r
      assign r_nbr = shadow[i-1];
    end
    deser_cell u_cell (
      .clock     (clock),
      .reset     (clr),
      .en        (take),
      .dir       (RightIn),
      .left_nbr  (l_nbr),
      .right_nbr (r_nbr),
      .q         (shadow[i])
    );
  end

  // Word as it will look once the final bit lands, so Q loads on that edge
  always_comb begin
    word_n = RightIn ? {SerialIn, shadow[WIDTH-1:1]}
                     : {shadow[WIDTH-2:0], SerialIn};
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (Start) state_n = SHIFT;
      SHIFT: begin
        if (last) begin
`ifdef PARITY_CHECK_EN
          state_n = PARITY;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: if (ShiftEn) state_n = DONE;
`endif
      DONE:  if (Ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr)
      count <= '0;
    else if (take && !last)
      count <= count + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      Q <= '0;
    else if (last)
      Q <= word_n;
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset)
      ParityErr <= 1'b0;
    else if ((state == PARITY) && ShiftEn)
      ParityErr <= ^{Q, SerialIn};
  end
`else
  assign ParityErr = 1'b0;
`endif

  assign Valid = (state == DONE);
  assign Busy  = (state == SHIFT) || (state == PARITY);

endmodule
